// File: rtl/led_blink_array_pkg.sv
// Shared definitions for the multi-channel LED blinker: mode encodings and a
// width helper used to size the prescaler and half-period counters.
package led_pkg;

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/led_blink_array_if.sv
// Board-side signal bundle of the LED blinker: switch/mode/enable inputs in,
// LED drive and prescaler debug tick out.
interface led_blink_array_if #(
  parameter int N_CH   = 4,
  parameter int RATE_W = 3
);
  logic [N_CH*RATE_W-1:0] switch_sel;
  logic [N_CH*2-1:0]      mode;
  logic [N_CH-1:0]        enable_pin;
  logic [N_CH-1:0]        led_out;
  logic                   base_tick;

  modport master (
    output switch_sel, mode, enable_pin,
    input  led_out, base_tick
  );

  modport slave (
    input  switch_sel, mode, enable_pin,
    output led_out, base_tick
  );
endinterface

// File: rtl/led_blink_array_channel.sv
// One LED channel: applied rate/mode registers, half-period counters, mode
// decode and the enable-gated output register.
module led_blink_channel
  import led_pkg::*;
#(
  parameter int RATE_W  = 3,
  parameter int BURST_N = 3
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              tick,
  input  logic [RATE_W-1:0] sel_sync,
  input  logic [1:0]        mode_sync,
  input  logic              en_sync,
  output logic              led
);

  localparam int TW       = 2 ** RATE_W;
  localparam int HP_N     = 4 * BURST_N;
  localparam int HW       = clog2(HP_N);
  localparam int BURST_ON = 2 * BURST_N;

  logic [RATE_W-1:0] sel_q, sel_d;
  logic [1:0]        mode_q, mode_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [HW-1:0]     hp_idx_q, hp_idx_d;
  logic              led_q, led_d;

  logic              restart;
  logic              hp_end;
  logic              raw;
  logic [TW-1:0]     hp_last;
  logic [HW-1:0]     hp_next;

  always_comb begin
    restart = ({sel_sync, mode_sync} != {sel_q, mode_q});
    hp_last = (TW'(1) << sel_q) - TW'(1);
    hp_end  = tick && (tick_cnt_q == hp_last);

    case (mode_q)
      MODE_BLINK: hp_next = (hp_idx_q == '0) ? HW'(1) : '0;
      MODE_BURST: hp_next = (hp_idx_q == HW'(HP_N - 1)) ? '0 : hp_idx_q + HW'(1);
      default:    hp_next = '0;
    endcase

    sel_d      = sel_q;
    mode_d     = mode_q;
    tick_cnt_d = tick_cnt_q;
    hp_idx_d   = hp_idx_q;
    // A new setting wins over a coincident tick so every restart begins with a full ON phase.
    if (restart) begin
      sel_d      = sel_sync;
      mode_d     = mode_sync;
      tick_cnt_d = '0;
      hp_idx_d   = '0;
    end else if (hp_end) begin
      tick_cnt_d = '0;
      hp_idx_d   = hp_next;
    end else if (tick) begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end

    case (mode_q)
      MODE_ON:    raw = 1'b1;
      MODE_BLINK: raw = ~hp_idx_q[0];
      MODE_BURST: raw = (hp_idx_q < HW'(BURST_ON)) && !hp_idx_q[0];
      default:    raw = 1'b0;
    endcase

    led_d = raw & en_sync;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sel_q      <= '0;
      mode_q     <= MODE_OFF;
      tick_cnt_q <= '0;
      hp_idx_q   <= '0;
      led_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      tick_cnt_q <= tick_cnt_d;
      hp_idx_q   <= hp_idx_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/led_blink_array.sv
// Multi-channel LED blinker top: shared BASE_HZ prescaler, input
// synchronisers and one independent blink channel per LED.
module led_blink_array
  import led_pkg::*;
#(
  parameter int CLK_HZ      = 25000000,
  parameter int BASE_HZ     = 200,
  parameter int N_CH        = 4,
  parameter int RATE_W      = 3,
  parameter int BURST_N     = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  led_blink_array_if.slave io
);

  localparam int DIV   = CLK_HZ / BASE_HZ;
  localparam int PRE_W = clog2(DIV);
  localparam int SW    = N_CH * (RATE_W + 3);

  if ((DIV < 2) || (DIV * BASE_HZ != CLK_HZ)) begin : g_bad_div
    $error("led_blink_array: CLK_HZ/BASE_HZ must divide exactly and be >= 2");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("led_blink_array: N_CH must be >= 1");
  end
  if (BURST_N < 1) begin : g_bad_burst
    $error("led_blink_array: BURST_N must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("led_blink_array: SYNC_STAGES must be >= 2");
  end

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tick_q, tick_d;

  // The tick flop is loaded from the next count so it is high exactly while pre_cnt sits at DIV-1.
  always_comb begin
    pre_cnt_d = (pre_cnt_q == PRE_W'(DIV - 1)) ? '0 : pre_cnt_q + PRE_W'(1);
    tick_d    = (pre_cnt_d == PRE_W'(DIV - 1));
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_d [SYNC_STAGES];

  always_comb begin
    sync_d[0] = {io.enable_pin, io.mode, io.switch_sel};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  logic [SW-1:0]          sync_last;
  logic [N_CH*RATE_W-1:0] sel_sync;
  logic [N_CH*2-1:0]      mode_sync;
  logic [N_CH-1:0]        en_sync;
  logic [N_CH-1:0]        led_vec;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign sel_sync  = sync_last[N_CH*RATE_W-1:0];
  assign mode_sync = sync_last[N_CH*RATE_W +: 2*N_CH];
  assign en_sync   = sync_last[SW-1 -: N_CH];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      led_blink_channel #(
        .RATE_W  (RATE_W),
        .BURST_N (BURST_N)
      ) u_ch (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .tick      (tick_q),
        .sel_sync  (sel_sync[gi*RATE_W +: RATE_W]),
        .mode_sync (mode_sync[2*gi +: 2]),
        .en_sync   (en_sync[gi]),
        .led       (led_vec[gi])
      );
    end
  endgenerate

  assign io.led_out   = led_vec;
  assign io.base_tick = tick_q;

endmodule

// File: tb/tb_led_blink_array.sv
// Scoreboard bench for led_blink_array: stimulus pushes hand-computed
// expectations keyed by cycle number, a monitor pops and compares them.
module tb_led_blink_array;
  import led_pkg::*;

  localparam int N_CH   = 2;
  localparam int RATE_W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_blink_array_if #(.N_CH(N_CH), .RATE_W(RATE_W)) io ();

  led_blink_array #(
    .CLK_HZ      (1000),
    .BASE_HZ     (100),
    .N_CH        (N_CH),
    .RATE_W      (RATE_W),
    .BURST_N     (3),
    .SYNC_STAGES (2)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io        (io)
  );

  typedef struct {
    int         cyc_at;
    bit         async_chk;
    bit         chk_tick;
    logic [1:0] exp_led;
    logic       exp_tick;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Cycle number = rising edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic exp_led(input int c, input logic [1:0] v, input string nm);
    exp_t e;
    e.cyc_at = c; e.async_chk = 1'b0; e.chk_tick = 1'b0;
    e.exp_led = v; e.exp_tick = 1'b0; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_tick(input int c, input logic v, input string nm);
    exp_t e;
    e.cyc_at = c; e.async_chk = 1'b0; e.chk_tick = 1'b1;
    e.exp_led = 2'b00; e.exp_tick = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_async(input string nm);
    exp_t e;
    e.cyc_at = 0; e.async_chk = 1'b1; e.chk_tick = 1'b0;
    e.exp_led = 2'b00; e.exp_tick = 1'b0; e.name = {nm, "_led"};
    sb.push_back(e);
    e.chk_tick = 1'b1; e.name = {nm, "_tick"};
    sb.push_back(e);
  endtask

  task automatic check_entry(input exp_t e);
    checks++;
    if (e.chk_tick) begin
      if (io.base_tick !== e.exp_tick) begin
        errors++;
        $display("FAIL %s cyc=%0d base_tick got %b want %b", e.name, cyc, io.base_tick, e.exp_tick);
      end else begin
        $display("ok   %s cyc=%0d base_tick=%b", e.name, cyc, io.base_tick);
      end
    end else begin
      if (io.led_out !== e.exp_led) begin
        errors++;
        $display("FAIL %s cyc=%0d led_out got %b want %b", e.name, cyc, io.led_out, e.exp_led);
      end else begin
        $display("ok   %s cyc=%0d led_out=%b", e.name, cyc, io.led_out);
      end
    end
  endtask

  // Monitor: compares due entries just after each falling clock edge and right after reset assertion.
  initial begin
    forever begin
      @(negedge clk or negedge rst_n);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if ((sb[i].async_chk && !rst_n) || (!sb[i].async_chk && sb[i].cyc_at == cyc)) begin
          check_entry(sb[i]);
          sb.delete(i);
        end else if (!sb[i].async_chk && sb[i].cyc_at < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missed cyc_at=%0d now=%0d", sb[i].name, sb[i].cyc_at, cyc);
          sb.delete(i);
        end
      end
    end
  end

  task automatic at(input int c);
    int n;
    n = 0;
    while (cyc != c && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != c) begin
      checks++;
      errors++;
      $display("FAIL at_timeout cyc got %0d want %0d", cyc, c);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  initial begin
    // 1: reset held with every input active
    io.switch_sel = '1;
    io.mode       = '1;
    io.enable_pin = '1;
    exp_led(0, 2'b00, "rst_hold_led");
    exp_tick(0, 1'b0, "rst_hold_tick");
    repeat (4) @(negedge clk);
    exp_led(0, 2'b00, "rst_hold2_led");
    exp_tick(0, 1'b0, "rst_hold2_tick");
    @(negedge clk);
    io.switch_sel = '0;
    io.mode       = '0;
    io.enable_pin = '0;
    rst_n = 1'b1;
    exp_led(1, 2'b00, "post_rst_led");
    exp_tick(8, 1'b0, "tick_c8");
    exp_tick(9, 1'b1, "tick_c9");
    exp_tick(10, 1'b0, "tick_c10");
    exp_tick(19, 1'b1, "tick_c19");
    exp_tick(29, 1'b1, "tick_c29");

    // 2: ch0 BLINK at sel 0
    at(100);
    io.mode[1:0]       = MODE_BLINK;
    io.switch_sel[2:0] = 3'd0;
    io.enable_pin      = 2'b11;
    exp_led(103, 2'b00, "blink_pre");
    exp_led(104, 2'b01, "blink_rise");
    exp_led(110, 2'b01, "blink_hi_end");
    exp_led(111, 2'b00, "blink_lo");
    exp_led(120, 2'b00, "blink_lo_end");
    exp_led(121, 2'b01, "blink_hi2");
    exp_led(131, 2'b00, "blink_lo2");

    // 3: ch0 sel 2, ch1 ON
    at(150);
    io.switch_sel[2:0] = 3'd2;
    io.mode[3:2]       = MODE_ON;
    exp_led(153, 2'b00, "sel2_pre");
    exp_led(154, 2'b11, "sel2_rise");
    exp_led(190, 2'b11, "sel2_hi_end");
    exp_led(191, 2'b10, "sel2_lo");
    exp_led(230, 2'b10, "sel2_lo_end");
    exp_led(231, 2'b11, "sel2_hi2");
    exp_led(270, 2'b11, "sel2_hi2_end");
    exp_led(271, 2'b10, "sel2_lo2");

    // 4: ch0 BURST at sel 0
    at(300);
    io.mode[1:0]       = MODE_BURST;
    io.switch_sel[2:0] = 3'd0;
    exp_led(303, 2'b10, "burst_pre");
    exp_led(304, 2'b11, "burst_p1");
    exp_led(311, 2'b10, "burst_lo1");
    exp_led(321, 2'b11, "burst_p2");
    exp_led(341, 2'b11, "burst_p3");
    exp_led(351, 2'b10, "burst_gap");
    exp_led(420, 2'b10, "burst_gap_end");
    exp_led(421, 2'b11, "burst_f2");
    exp_led(540, 2'b10, "burst_f2_gap");
    exp_led(541, 2'b11, "burst_f3");

    // 5: enable gating preserves phase
    at(543);
    io.enable_pin[0] = 1'b0;
    exp_led(545, 2'b11, "en_off_lat");
    exp_led(546, 2'b10, "en_off");
    exp_led(550, 2'b10, "en_off_hold");
    exp_led(561, 2'b11, "en_phase_hi");
    exp_led(571, 2'b10, "en_phase_lo");
    exp_led(581, 2'b11, "en_phase_hi2");
    at(553);
    io.enable_pin[0] = 1'b1;

    // 6: mode change in a low half-period restarts with ON
    at(593);
    io.mode[1:0] = MODE_BLINK;
    exp_led(596, 2'b10, "rst_mode_pre");
    exp_led(597, 2'b11, "rst_mode_on");
    exp_led(600, 2'b11, "rst_mode_on_end");
    exp_led(601, 2'b10, "rst_mode_lo");
    exp_led(611, 2'b11, "rst_mode_hi");

    // Asynchronous reset between edges, then resume from reset state
    at(620);
    #2;
    exp_async("async_rst");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_led(3, 2'b00, "resume_pre");
    exp_led(4, 2'b11, "resume_rise");
    exp_tick(9, 1'b1, "resume_tick");
    exp_led(10, 2'b11, "resume_hi_end");
    exp_led(11, 2'b10, "resume_lo");

    at(30);
    for (int i = 0; i < sb.size(); i++) begin
      checks++;
      errors++;
      $display("FAIL %s never_checked cyc_at=%0d", sb[i].name, sb[i].cyc_at);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
